// File: rtl/lsu_dcache_arbiter.sv
// Arbitrates the LSU load path and store-buffer drain onto one D-cache port, one transaction in flight.
// Latency: accept -> dc_req_valid +1, zero-wait response -> result pulse +3; next accept in the pulse cycle.
// Backpressure: requester ready only in IDLE for the granted side; cache request held until dc_req_ready.
module lsu_dcache_arbiter #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    parameter int SB_W       = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                ld_req_valid,
    output logic                ld_req_ready,
    input  logic [DATA_W-1:0]   ld_req_addr,
    input  logic [TAG_W-1:0]    ld_req_tag,
    input  logic                st_req_valid,
    output logic                st_req_ready,
    input  logic [DATA_W-1:0]   st_req_addr,
    input  logic [DATA_W-1:0]   st_req_data,
    input  logic [DATA_W/8-1:0] st_req_strb,
    input  logic [SB_W-1:0]     st_req_sb_id,
    input  logic                st_urgent_i,
    output logic                dc_req_valid,
    input  logic                dc_req_ready,
    output logic                dc_req_we,
    output logic [DATA_W-1:0]   dc_req_addr,
    output logic [DATA_W-1:0]   dc_req_wdata,
    output logic [DATA_W/8-1:0] dc_req_strb,
    input  logic                dc_resp_valid,
    input  logic [DATA_W-1:0]   dc_resp_data,
    output logic                ld_resp_valid,
    output logic [TAG_W-1:0]    ld_resp_tag,
    output logic [DATA_W-1:0]   ld_resp_data,
    output logic                st_done_valid,
    output logic [SB_W-1:0]     st_done_sb_id
);

    localparam int          STRB_W     = DATA_W / 8;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t              state_q;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [TAG_W-1:0]    tag_q;
    logic [SB_W-1:0]     sb_id_q;
    logic                kill_q;
    logic [3:0]          starve_q;
    logic                ld_resp_valid_q;
    logic [TAG_W-1:0]    ld_resp_tag_q;
    logic [DATA_W-1:0]   ld_resp_data_q;
    logic                st_done_valid_q;
    logic [SB_W-1:0]     st_done_sb_id_q;

    logic idle;
    logic st_prio;
    logic ld_cand;
    logic ld_go;
    logic st_go;

    // A flushed load is not a candidate, so a concurrent store takes the slot.
    assign idle         = (state_q == IDLE);
    assign st_prio      = st_urgent_i | (starve_q >= STARVE_LIM);
    assign ld_cand      = ld_req_valid & ~flush_i;
    assign ld_req_ready = idle & ld_cand & ~(st_req_valid & st_prio);
    assign st_req_ready = idle & st_req_valid & ~(ld_cand & ~st_prio);
    assign ld_go        = ld_req_ready;
    assign st_go        = st_req_ready;

    assign dc_req_valid  = (state_q == REQ);
    assign dc_req_we     = we_q;
    assign dc_req_addr   = addr_q;
    assign dc_req_wdata  = wdata_q;
    assign dc_req_strb   = strb_q;
    assign ld_resp_valid = ld_resp_valid_q;
    assign ld_resp_tag   = ld_resp_tag_q;
    assign ld_resp_data  = ld_resp_data_q;
    assign st_done_valid = st_done_valid_q;
    assign st_done_sb_id = st_done_sb_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            strb_q          <= '0;
            tag_q           <= '0;
            sb_id_q         <= '0;
            kill_q          <= 1'b0;
            starve_q        <= '0;
            ld_resp_valid_q <= 1'b0;
            ld_resp_tag_q   <= '0;
            ld_resp_data_q  <= '0;
            st_done_valid_q <= 1'b0;
            st_done_sb_id_q <= '0;
        end else begin
            ld_resp_valid_q <= 1'b0;
            st_done_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (st_go) begin
                        we_q     <= 1'b1;
                        addr_q   <= st_req_addr;
                        wdata_q  <= st_req_data;
                        strb_q   <= st_req_strb;
                        sb_id_q  <= st_req_sb_id;
                        tag_q    <= '0;
                        starve_q <= '0;
                        state_q  <= REQ;
                    end else if (ld_go) begin
                        we_q    <= 1'b0;
                        addr_q  <= ld_req_addr;
                        wdata_q <= '0;
                        strb_q  <= '0;
                        tag_q   <= ld_req_tag;
                        sb_id_q <= '0;
                        if (st_req_valid && (starve_q != 4'hF))
                            starve_q <= starve_q + 4'd1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (dc_req_ready) begin
                        kill_q  <= 1'b0;
                        state_q <= (!we_q && (flush_i || kill_q)) ? DROP : WAIT;
                    end else if (flush_i && !we_q) begin
                        kill_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (we_q) begin
                        if (dc_resp_valid) begin
                            st_done_valid_q <= 1'b1;
                            st_done_sb_id_q <= sb_id_q;
                            state_q         <= IDLE;
                        end
                    end else if (dc_resp_valid) begin
                        if (!flush_i) begin
                            ld_resp_valid_q <= 1'b1;
                            ld_resp_tag_q   <= tag_q;
                            ld_resp_data_q  <= dc_resp_data;
                        end
                        state_q <= IDLE;
                    end else if (flush_i) begin
                        // The response is still owed by the cache; swallow it before reopening.
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (dc_resp_valid)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Bench for lsu_dcache_arbiter: directed requests, a simple cache model and a response scoreboard.
module tb_lsu_dcache_arbiter;

    localparam int DW = 32;
    localparam int TW = 6;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          ld_req_valid;
    logic          ld_req_ready;
    logic [DW-1:0] ld_req_addr;
    logic [TW-1:0] ld_req_tag;
    logic          st_req_valid;
    logic          st_req_ready;
    logic [DW-1:0] st_req_addr;
    logic [DW-1:0] st_req_data;
    logic [DW/8-1:0] st_req_strb;
    logic [SW-1:0] st_req_sb_id;
    logic          st_urgent_i;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic          dc_req_we;
    logic [DW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_wdata;
    logic [DW/8-1:0] dc_req_strb;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_data;
    logic          ld_resp_valid;
    logic [TW-1:0] ld_resp_tag;
    logic [DW-1:0] ld_resp_data;
    logic          st_done_valid;
    logic [SW-1:0] st_done_sb_id;

    lsu_dcache_arbiter #(.DATA_W(DW), .TAG_W(TW), .SB_W(SW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_addr(st_req_addr), .st_req_data(st_req_data),
        .st_req_strb(st_req_strb), .st_req_sb_id(st_req_sb_id),
        .st_urgent_i(st_urgent_i),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_strb(dc_req_strb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag),
        .ld_resp_data(ld_resp_data),
        .st_done_valid(st_done_valid), .st_done_sb_id(st_done_sb_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            is_ld;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [SW-1:0] sb;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   auto_resp = 1'b1;
    logic          c_hs;
    logic [DW-1:0] c_addr;

    function automatic logic [DW-1:0] mem_rd(logic [DW-1:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic void push_ld(logic [DW-1:0] a, logic [TW-1:0] t);
        exp_t e;
        e.is_ld = 1'b1; e.tag = t; e.data = mem_rd(a); e.sb = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_st(logic [SW-1:0] s);
        exp_t e;
        e.is_ld = 1'b0; e.tag = '0; e.data = '0; e.sb = s;
        exp_q.push_back(e);
    endfunction

    // Zero-wait cache: answers one cycle after each accepted request.
    initial begin
        forever begin
            @(negedge clk);
            c_hs   = dc_req_valid && dc_req_ready;
            c_addr = dc_req_addr;
            @(posedge clk);
            #1;
            if (auto_resp) begin
                dc_resp_valid = c_hs;
                dc_resp_data  = c_hs ? mem_rd(c_addr) : '0;
            end
        end
    end

    // Monitor: every result pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ld_resp_valid) begin
                if (exp_q.size() == 0) chk("ld_resp_unexpected", 32'(ld_resp_valid), 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ld_resp_kind", 32'(e.is_ld), 32'd1);
                    chk("ld_resp_tag", 32'(ld_resp_tag), 32'(e.tag));
                    chk("ld_resp_data", ld_resp_data, e.data);
                end
            end
            if (rst_n && st_done_valid) begin
                if (exp_q.size() == 0) chk("st_done_unexpected", 32'(st_done_valid), 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("st_done_kind", 32'(e.is_ld), 32'd0);
                    chk("st_done_sb_id", 32'(st_done_sb_id), 32'(e.sb));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ld(logic [DW-1:0] a, logic [TW-1:0] t);
        bit acc;
        acc = 1'b0;
        ld_req_addr = a; ld_req_tag = t; ld_req_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = ld_req_ready;
            step();
        end
        ld_req_valid = 1'b0;
        chk("ld_accept", 32'(acc), 32'd1);
    endtask

    task automatic issue_st(logic [DW-1:0] a, logic [DW-1:0] d, logic [3:0] s, logic [SW-1:0] id);
        bit acc;
        acc = 1'b0;
        st_req_addr = a; st_req_data = d; st_req_strb = s; st_req_sb_id = id; st_req_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = st_req_ready;
            step();
        end
        st_req_valid = 1'b0;
        chk("st_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic set_ld(int n);
        ld_req_addr = 32'h200 + 32'(4 * n);
        ld_req_tag  = TW'(n);
    endtask

    task automatic set_st(int n);
        st_req_addr  = 32'h300 + 32'(4 * n);
        st_req_data  = {8{4'(n)}};
        st_req_strb  = 4'h3;
        st_req_sb_id = SW'(n);
    endtask

    // Hold both requesters valid, advancing each payload as it is granted.
    task automatic both(int nl, int ns, int lb, int sb);
        int li, si;
        bit lh, sh;
        li = 0; si = 0;
        set_ld(lb); set_st(sb);
        ld_req_valid = (nl > 0);
        st_req_valid = (ns > 0);
        for (int c = 0; c < 300 && (li < nl || si < ns); c++) begin
            @(negedge clk);
            lh = ld_req_valid && ld_req_ready;
            sh = st_req_valid && st_req_ready;
            step();
            if (lh) begin
                li++;
                if (li < nl) set_ld(lb + li); else ld_req_valid = 1'b0;
            end
            if (sh) begin
                si++;
                if (si < ns) set_st(sb + si); else st_req_valid = 1'b0;
            end
        end
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
        chk("arb_grant_count", 32'(li + si), 32'(nl + ns));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; st_urgent_i = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_tag = '0;
        st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_strb = '0; st_req_sb_id = '0;
        dc_req_ready = 1'b1; dc_resp_valid = 1'b0; dc_resp_data = '0;
        repeat (2) step();
        chk("rst_dc_req_valid", 32'(dc_req_valid), 32'd0);
        chk("rst_ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        chk("rst_st_done_valid", 32'(st_done_valid), 32'd0);
        chk("rst_dc_req_addr", dc_req_addr, 32'd0);
        rst_n = 1'b1;
        step();

        // Single load, zero-wait cache: pulse three cycles after accept.
        push_ld(32'h100, 6'd5);
        issue_ld(32'h100, 6'd5);
        @(negedge clk);
        chk("ld_dc_req_valid", 32'(dc_req_valid), 32'd1);
        chk("ld_dc_req_we", 32'(dc_req_we), 32'd0);
        chk("ld_dc_req_addr", dc_req_addr, 32'h100);
        chk("ld_dc_req_strb", 32'(dc_req_strb), 32'd0);
        chk("ld_dc_req_wdata", dc_req_wdata, 32'd0);
        @(negedge clk);
        chk("ld_resp_early", 32'(ld_resp_valid), 32'd0);
        @(negedge clk);
        chk("ld_resp_at_3", 32'(ld_resp_valid), 32'd1);
        chk("ld_no_st_done", 32'(st_done_valid), 32'd0);
        wait_drain();

        // Single store stalled by the cache for 4 cycles.
        dc_req_ready = 1'b0;
        push_st(4'd3);
        issue_st(32'h40, 32'h12345678, 4'hF, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_hold_valid", 32'(dc_req_valid), 32'd1);
            chk("st_hold_we", 32'(dc_req_we), 32'd1);
            chk("st_hold_addr", dc_req_addr, 32'h40);
            chk("st_hold_wdata", dc_req_wdata, 32'h12345678);
            chk("st_hold_strb", 32'(dc_req_strb), 32'hF);
        end
        step();
        dc_req_ready = 1'b1;
        wait_drain();

        // Starvation: 4 loads then 1 store, twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_ld(32'h200 + 32'(4 * (r * 4 + k)), TW'(r * 4 + k));
            push_st(SW'(r));
        end
        both(8, 2, 0, 0);
        wait_drain();

        // Urgent store goes ahead of a concurrent load.
        st_urgent_i = 1'b1;
        push_st(4'd5);
        push_ld(32'h220, 6'd8);
        both(1, 1, 8, 5);
        st_urgent_i = 1'b0;
        wait_drain();

        // Flush while the load waits in REQ: response is swallowed.
        dc_req_ready = 1'b0;
        issue_ld(32'h500, 6'd9);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        dc_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_req_no_resp", 32'(ld_resp_valid), 32'd0);
        end
        step();
        push_ld(32'h600, 6'd10);
        issue_ld(32'h600, 6'd10);
        wait_drain();

        // Flush during a store in WAIT is ignored.
        auto_resp = 1'b0;
        push_st(4'd6);
        issue_st(32'h80, 32'hCAFEF00D, 4'hC, 4'd6);
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_data = '0;
        step();
        dc_resp_valid = 1'b0;
        wait_drain();

        // Flush coincident with a load response suppresses the pulse.
        issue_ld(32'h700, 6'd11);
        step();
        flush_i = 1'b1;
        dc_resp_valid = 1'b1;
        dc_resp_data = 32'hBAD;
        step();
        flush_i = 1'b0;
        dc_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_wait_no_resp", 32'(ld_resp_valid), 32'd0);
        end
        step();
        auto_resp = 1'b1;
        push_ld(32'h708, 6'd12);
        issue_ld(32'h708, 6'd12);
        wait_drain();

        // Reset while waiting on a load; a late response is ignored.
        auto_resp = 1'b0;
        issue_ld(32'h800, 6'd13);
        step();
        rst_n = 1'b0;
        #1;
        chk("wrst_dc_req_valid", 32'(dc_req_valid), 32'd0);
        chk("wrst_dc_req_addr", dc_req_addr, 32'd0);
        chk("wrst_ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        chk("wrst_st_done_valid", 32'(st_done_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        dc_resp_valid = 1'b1;
        dc_resp_data = 32'h55;
        step();
        dc_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_resp_no_pulse", 32'(ld_resp_valid), 32'd0);
        end
        step();
        auto_resp = 1'b1;
        push_ld(32'h900, 6'd14);
        issue_ld(32'h900, 6'd14);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_arbiter.md
Name: lsu_dcache_arbiter

Overview:
Sequences the single D-cache request port shared by the LSU load path (loads issued from the LSU reservation station) and the store-buffer drain path (committed stores). The block captures one request at a time, presents it to the cache with a valid/ready handshake, and returns the response to its owner. It keeps at most one cache transaction outstanding. Loads are killed on flush; committed stores are never killed. Sits between the LSU execute stage and the D-cache.

Parameters:
DATA_W, 32, data and address width
TAG_W, 6, ROB tag width of a load
SB_W, 4, store buffer entry id width
STARVE_MAX, 4, consecutive load grants after which a pending store wins; range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; kills the pending or in-flight load
ld_req_valid  in  1  load request
ld_req_ready  out  1  load accepted this cycle
ld_req_addr  in  DATA_W  load address
ld_req_tag  in  TAG_W  load destination tag
st_req_valid  in  1  store drain request
st_req_ready  out  1  store accepted this cycle
st_req_addr  in  DATA_W  store address
st_req_data  in  DATA_W  store data
st_req_strb  in  DATA_W/8  byte strobes
st_req_sb_id  in  SB_W  store buffer id
st_urgent_i  in  1  store buffer nearly full; stores get priority
dc_req_valid  out  1  cache request valid
dc_req_ready  in  1  cache accepts request
dc_req_we  out  1  1 = store
dc_req_addr  out  DATA_W  request address
dc_req_wdata  out  DATA_W  store data
dc_req_strb  out  DATA_W/8  store strobes; all zero for loads
dc_resp_valid  in  1  cache response (load data or store ack)
dc_resp_data  in  DATA_W  load data
ld_resp_valid  out  1  load result pulse
ld_resp_tag  out  TAG_W  tag of the returned load
ld_resp_data  out  DATA_W  load data
st_done_valid  out  1  store-complete pulse
st_done_sb_id  out  SB_W  id of the completed store

Behaviour:
- State machine states: IDLE, REQ, WAIT, DROP. Registered holding regs store we, addr, wdata, strb, tag, and sb_id. An async reset puts the block in IDLE with every output register, holding reg and starve_cnt at 0.
- Each ready output is combinational and can be 1 only in IDLE. A requester is accepted in the cycle where its valid and ready are both 1. Request fields are latched on that edge and the state moves to REQ.
- Arbitration in IDLE:
  - If both requesters are valid, the store wins when st_urgent_i=1 or starve_cnt>=STARVE_MAX. Otherwise the load wins.
  - A load grant while a store is pending increments starve_cnt, saturating at 15.
  - Any store grant clears starve_cnt.
  - With a single valid requester, that requester is granted.
  - A load is not accepted while flush_i=1, so ld_req_ready=0 in that cycle. A store is still accepted during flush.
- REQ: dc_req_valid=1 and the dc_req_* fields come from the holding regs.
  - The request is held stable until dc_req_ready=1 and is never retracted.
  - On acceptance, the state goes to WAIT. If the request is a load and a flush arrives in the same cycle or arrived earlier while in REQ, the state goes to DROP instead.
  - A sticky kill bit records a flush seen in REQ for a load.
- WAIT: on dc_resp_valid the state returns to IDLE.
  - For a load, ld_resp_valid pulses for one cycle in the cycle after dc_resp_valid, carrying the latched tag and the response data.
  - For a store, st_done_valid pulses with the latched sb_id.
  - A flush_i while waiting on a load (flush arriving before or with dc_resp_valid) suppresses the pulse and the state returns to IDLE. The outcome is identical to DROP.
  - A store in WAIT ignores flush.
- DROP: wait for dc_resp_valid, discard it, then go to IDLE. No pulses are produced.
- A dc_resp_valid outside WAIT/DROP is ignored.
- Minimum transaction: accept at cycle 0, dc_req_valid at cycle 1, response at cycle 2 (zero-wait cache), result pulse at cycle 3, next accept at cycle 3. Throughput is therefore one transaction per 3 cycles at best.
- dc_req_strb is 0 and dc_req_wdata is 0 for loads.

Test Plan:
- Single load: addr=0x100, tag=5; cache accepts immediately and returns 0xDEADBEEF one cycle later -> ld_resp_valid=1, tag=5, data=0xDEADBEEF exactly 3 cycles after accept. No st_done_valid.
- Single store: sb_id=3, data=0x12345678, strb=4'b1111; dc_req_ready held 0 for 4 cycles -> dc_req_valid and the dc_req_* fields stay stable throughout; after the ack, st_done_valid=1 with sb_id=3.
- Starvation with STARVE_MAX=4: load and store both valid continuously, st_urgent_i=0 -> 4 load grants, then 1 store grant, then the pattern repeats. With st_urgent_i=1 the store is granted first.
- Flush in REQ: load accepted, dc_req_ready=0, flush_i pulsed, then the cache accepts and responds -> no ld_resp_valid; state returns to IDLE and the next request is accepted normally.
- Flush during a store in WAIT -> st_done_valid still fires. A flush during a load in WAIT coincident with dc_resp_valid -> no ld_resp_valid.
- rst_n asserted low while in WAIT -> all outputs are 0 immediately. A late dc_resp_valid after reset release produces no pulse.
